// File: rtl/beam_scaler_pkg.sv
// beam_scaler_pkg: shared constants, period controller states and width helper
package beam_scaler_pkg;
  localparam string MODE_EDGE = "EDGE";
  localparam string MODE_LEVEL = "LEVEL";
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LATCH} state_t;
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/beam_scaler_counter.sv
// beam_scaler_counter: one beam's edge detect, saturating counter and sticky saturated flag
module beam_scaler_counter
  import beam_scaler_pkg::*;
#(
  parameter int SCALER_WIDTH = 16,
  parameter string COUNT_MODE = MODE_EDGE
) (
  input  logic                    ifclk,
  input  logic                    rst_i,
  input  logic                    event_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  output logic [SCALER_WIDTH-1:0] count_o,
  output logic                    sat_o
);
  localparam bit LEVEL = (COUNT_MODE == MODE_LEVEL);
  logic                    r_q;
  logic                    r_sat;
  logic [SCALER_WIDTH-1:0] r_cnt;
  logic                    w_ev;
  logic [SCALER_WIDTH-1:0] w_nxt;
  // clear_i restarts the count with this cycle's event so nothing is lost across a latch
  assign w_ev = en_i & event_i & (LEVEL | ~r_q);
  assign w_nxt = clear_i ? SCALER_WIDTH'(w_ev) : (&r_cnt) ? r_cnt : r_cnt + SCALER_WIDTH'(w_ev);
  // history runs in every state; the saturated flag sticks until the next clear
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      r_q   <= event_i;
      r_cnt <= w_nxt;
      r_sat <= (clear_i ? 1'b0 : r_sat) | (&w_nxt);
    end
  end
  assign count_o = r_cnt;
  assign sat_o = r_sat;
endmodule

// File: rtl/beam_scaler_bank.sv
// beam_scaler_bank: per-beam gated trigger scalers with snapshot holding registers and registered read port
module beam_scaler_bank
  import beam_scaler_pkg::*;
#(
  parameter int NBEAMS = 48,
  parameter int SCALER_WIDTH = 16,
  parameter int PERIOD_WIDTH = 32,
  parameter string COUNT_MODE = MODE_EDGE
) (
  input  logic                        ifclk,
  input  logic                        rst_i,
  input  logic [NBEAMS-1:0]           trigger_i,
  input  logic                        enable_i,
  input  logic [PERIOD_WIDTH-1:0]     period_i,
  input  logic                        rd_i,
  input  logic [addr_w(NBEAMS)-1:0]   addr_i,
  output logic [SCALER_WIDTH-1:0]     dat_o,
  output logic                        valid_o,
  output logic                        update_o,
  output logic [NBEAMS-1:0]           sat_o
);
  localparam int AW = addr_w(NBEAMS);
  localparam logic [AW:0] NB = (AW + 1)'(NBEAMS);
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_timer;
  logic [PERIOD_WIDTH-1:0] w_timer_nxt;
  logic                    w_start;
  logic [SCALER_WIDTH-1:0] w_cnt [NBEAMS];
  logic [NBEAMS-1:0]       w_sat;
  logic [SCALER_WIDTH-1:0] r_hold [NBEAMS];
  logic [NBEAMS-1:0]       r_sat;
  logic [SCALER_WIDTH-1:0] r_dat;
  logic                    r_valid;
  logic                    r_upd;
  assign w_start = enable_i && (period_i != '0);
  // period controller: next state and timer
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = w_start ? S_RUN : S_IDLE;
        w_timer_nxt = w_start ? period_i - PERIOD_WIDTH'(1) : '0;
      end
      S_RUN: begin
        w_state_nxt = !enable_i ? S_IDLE : (r_timer == '0) ? S_LATCH : S_RUN;
        w_timer_nxt = (!enable_i || r_timer == '0) ? '0 : r_timer - PERIOD_WIDTH'(1);
      end
      S_LATCH: begin
        w_state_nxt = w_start ? S_RUN : S_IDLE;
        w_timer_nxt = w_start ? period_i - PERIOD_WIDTH'(1) : '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end
  // period controller state and timer registers
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
    end
  end
  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    beam_scaler_counter #(
      .SCALER_WIDTH(SCALER_WIDTH),
      .COUNT_MODE  (COUNT_MODE)
    ) u_cnt (
      .ifclk  (ifclk),
      .rst_i  (rst_i),
      .event_i(trigger_i[b]),
      .en_i   (r_state != S_IDLE),
      .clear_i(r_state != S_RUN),
      .count_o(w_cnt[b]),
      .sat_o  (w_sat[b])
    );
  end
  // snapshot all counters and saturation flags on the latch cycle
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      r_hold <= '{default: '0};
      r_sat  <= '0;
      r_upd  <= 1'b0;
    end else begin
      r_upd <= (r_state == S_LATCH);
      if (r_state == S_LATCH) begin
        r_hold <= w_cnt;
        r_sat  <= w_sat;
      end
    end
  end
  // registered read mux; out-of-range beams read as zero
  always_ff @(posedge ifclk) begin
    if (rst_i) begin
      r_dat   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rd_i;
      if (rd_i) r_dat <= ({1'b0, addr_i} < NB) ? r_hold[addr_i] : '0;
    end
  end
  assign dat_o = r_dat;
  assign valid_o = r_valid;
  assign update_o = r_upd;
  assign sat_o = r_sat;
endmodule

// File: tb/tb_beam_scaler_bank.sv
// tb_beam_scaler_bank: scoreboard bench for the beam scaler bank (EDGE/16-bit and LEVEL/4-bit instances)
module tb_beam_scaler_bank;
  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] trg_a;
  logic        en_a;
  logic [31:0] per_a;
  logic        rd_a;
  logic [5:0]  addr_a;
  logic [15:0] dat_a;
  logic        val_a;
  logic        upd_a;
  logic [47:0] sat_a;
  logic [3:0]  trg_b;
  logic        en_b;
  logic [31:0] per_b;
  logic        rd_b;
  logic [1:0]  addr_b;
  logic [3:0]  dat_b;
  logic        val_b;
  logic        upd_b;
  logic [3:0]  sat_b;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          upd_cnt_a = 0;
  int          qa[$];
  int          qb[$];

  beam_scaler_bank u_a (
    .ifclk(clk), .rst_i(rst), .trigger_i(trg_a), .enable_i(en_a), .period_i(per_a),
    .rd_i(rd_a), .addr_i(addr_a), .dat_o(dat_a), .valid_o(val_a), .update_o(upd_a), .sat_o(sat_a)
  );

  beam_scaler_bank #(.NBEAMS(4), .SCALER_WIDTH(4), .COUNT_MODE("LEVEL")) u_b (
    .ifclk(clk), .rst_i(rst), .trigger_i(trg_b), .enable_i(en_b), .period_i(per_b),
    .rd_i(rd_b), .addr_i(addr_b), .dat_o(dat_b), .valid_o(val_b), .update_o(upd_b), .sat_o(sat_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every presented read result is matched against the oldest expectation
  always @(negedge clk) begin
    if (upd_a) upd_cnt_a++;
    if (val_a) begin
      if (qa.size() == 0) chk("read_a_unexpected", 1, 0);
      else chk("read_a", int'(dat_a), qa.pop_front());
    end
    if (val_b) begin
      if (qb.size() == 0) chk("read_b_unexpected", 1, 0);
      else chk("read_b", int'(dat_b), qb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic read_a(input int a, input int exp);
    rd_a = 1'b1;
    addr_a = 6'(a);
    qa.push_back(exp);
    tick();
    rd_a = 1'b0;
  endtask

  task automatic read_b(input int a, input int exp);
    rd_b = 1'b1;
    addr_b = 2'(a);
    qb.push_back(exp);
    tick();
    rd_b = 1'b0;
  endtask

  task automatic wait_upd(input bit sel, input int lim, output int c);
    c = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (sel ? upd_b : upd_a) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) chk("update_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, d1, d2, d3;
    rst = 1'b1;
    trg_a = '0; en_a = 1'b0; per_a = '0; rd_a = 1'b0; addr_a = '0;
    trg_b = '0; en_b = 1'b0; per_b = '0; rd_b = 1'b0; addr_b = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_dat", int'(dat_a), 0);
    chk("rst_valid", int'(val_a), 0);
    chk("rst_update", int'(upd_a), 0);
    chk("rst_sat", int'(sat_a != '0), 0);
    chk("rst_b_dat", int'(dat_b), 0);
    u0 = upd_cnt_a;
    repeat (100) tick();
    chk("idle_no_update", upd_cnt_a - u0, 0);
    read_a(5, 0);
    // basic edge counting: 10 rising edges on beam 3
    per_a = 100;
    en_a = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      trg_a[3] = 1'b1; tick();
      trg_a[3] = 1'b0; tick();
    end
    wait_upd(0, 200, c1);
    read_a(3, 10);
    read_a(0, 0);
    read_a(47, 0);
    read_a(48, 0);
    read_a(63, 0);
    chk("sat_basic", int'(sat_a != '0), 0);
    // read issued on the latch cycle returns the pre-latch value
    tick_to(c1 + 100);
    read_a(3, 10);
    chk("latch_read_update", int'(upd_a), 1);
    c2 = cyc;
    chk("period_100", c2 - c1, 101);
    // rising edge on the latch cycle goes into the next period
    tick_to(c2 + 100);
    trg_a[3] = 1'b1;
    tick();
    chk("edge_on_latch_update", int'(upd_a), 1);
    c3 = cyc;
    trg_a[3] = 1'b0;
    read_a(3, 0);
    wait_upd(0, 200, c4);
    chk("period_100_b", c4 - c3, 101);
    read_a(3, 1);
    // mid-period abort discards 5 edges, holding unchanged
    for (int i = 0; i < 5; i++) begin
      trg_a[3] = 1'b1; tick();
      trg_a[3] = 1'b0; tick();
    end
    repeat (38) tick();
    en_a = 1'b0;
    u0 = upd_cnt_a;
    repeat (150) tick();
    chk("abort_no_update", upd_cnt_a - u0, 0);
    read_a(3, 1);
    en_a = 1'b1;
    c0 = cyc;
    wait_upd(0, 200, c5);
    chk("fresh_period", c5 - c0, 102);
    read_a(3, 0);
    // period change mid-period takes effect at the next reload
    repeat (29) tick();
    per_a = 20;
    wait_upd(0, 200, c6);
    chk("period_keep_100", c6 - c5, 101);
    wait_upd(0, 100, c7);
    chk("period_20", c7 - c6, 21);
    for (int i = 0; i < 2; i++) begin
      trg_a[3] = 1'b1; tick();
      trg_a[3] = 1'b0; tick();
    end
    wait_upd(0, 100, c8);
    chk("period_20_b", c8 - c7, 21);
    read_a(3, 2);
    // reset mid-period clears holding registers with no update
    repeat (9) tick();
    rst = 1'b1;
    en_a = 1'b0;
    tick();
    rst = 1'b0;
    u0 = upd_cnt_a;
    repeat (30) tick();
    chk("reset_no_update", upd_cnt_a - u0, 0);
    read_a(3, 0);
    chk("reset_sat", int'(sat_a != '0), 0);
    // period_i=1 latches every 2 cycles
    per_a = 1;
    en_a = 1'b1;
    wait_upd(0, 20, c9);
    wait_upd(0, 20, c10);
    chk("period_1", c10 - c9, 2);
    // period_i=0 keeps the controller idle
    per_a = 0;
    repeat (3) tick();
    u0 = upd_cnt_a;
    repeat (20) tick();
    chk("period_0_idle", upd_cnt_a - u0, 0);
    en_a = 1'b0;
    // LEVEL mode, 4-bit saturation on beam 0, 5 cycles high on beam 2
    trg_b = 4'b0001;
    per_b = 40;
    en_b = 1'b1;
    tick();
    trg_b[2] = 1'b1;
    repeat (5) tick();
    trg_b[2] = 1'b0;
    wait_upd(1, 100, d1);
    trg_b[0] = 1'b0;
    read_b(0, 15);
    read_b(2, 5);
    read_b(1, 0);
    chk("sat_b_set", int'(sat_b), 1);
    wait_upd(1, 100, d2);
    chk("period_40", d2 - d1, 41);
    read_b(0, 1);
    chk("sat_b_clear", int'(sat_b), 0);
    wait_upd(1, 100, d3);
    read_b(0, 0);
    repeat (3) tick();
    chk("scoreboard_empty", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
